decode_stage: RTL

//  Registered RV32I/RV64I instruction decode stage with valid/ready handshake on both sides.

---
 rtl/decode_stage.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// decode_stage -- registered RV32I/RV64I decode stage between fetch and execute.
//
// Takes a raw instruction and its pc from fetch through a valid/ready handshake.
// It splits out the register fields and classifies the instruction format.
// It sign-extends the immediate to XLEN and flags illegal encodings so that
// execute can trap. The decoded bundle is registered with a latency of one
// cycle. Back-to-back accepts give full throughput. A flush drops both the held
// bundle and the incoming instruction.
//
// Parameters:
//   XLEN   datapath width (32 or 64); width of pc and imm
//   CNT_W  statistics counter width (present only with DECODE_STATS_EN)
//
// Ports:
//   clk, rst (sync, active-high), flush
//   in_valid / in_ready / in_instr[31:0] / in_pc[XLEN-1:0]     fetch side
//   out_valid / out_ready                                      execute side
//   out_pc, out_opcode, out_funct3, out_funct7, out_rs1/rs2/rd (raw fields)
//   out_fmt (0=NONE 1=R 2=I 3=S 4=B 5=U 6=J), out_imm (sign-extended)
//   out_use_rs1, out_use_rs2, out_wr_rd, out_illegal
//
// Build option DECODE_STATS_EN: adds stat_decoded and stat_illegal, which are
// saturating counts of accepts and of illegal accepts. Only rst clears them.
module decode_stage #(
  parameter int unsigned XLEN = 32
`ifdef DECODE_STATS_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_imm,
  output logic            out_use_rs1,
  output logic            out_use_rs2,
  output logic            out_wr_rd,
  output logic            out_illegal
`ifdef DECODE_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_decoded,
  output logic [CNT_W-1:0] stat_illegal
`endif
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6
  } fmt_e;

  logic [6:0]      opc;
  logic [6:0]      f7;
  fmt_e            fmt_raw;
  fmt_e            fmt_d;
  logic            illegal_d;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_d;
  logic            use_rs1_d;
  logic            use_rs2_d;
  logic            wr_rd_d;
  logic            accept;

  assign opc      = in_instr[6:0];
  assign f7       = in_instr[31:25];
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    fmt_raw = FMT_NONE;
    case (opc)
      7'b0110011:                         fmt_raw = FMT_R;
      7'b0000011, 7'b0010011, 7'b1100111: fmt_raw = FMT_I;
      7'b0100011:                         fmt_raw = FMT_S;
      7'b1100011:                         fmt_raw = FMT_B;
      7'b0110111, 7'b0010111:             fmt_raw = FMT_U;
      7'b1101111:                         fmt_raw = FMT_J;
      7'b0011011: if (XLEN == 64)         fmt_raw = FMT_I;
      7'b0111011: if (XLEN == 64)         fmt_raw = FMT_R;
      default:                            fmt_raw = FMT_NONE;
    endcase
  end

  always_comb begin
    illegal_d = (in_instr[1:0] != 2'b11) || (fmt_raw == FMT_NONE) ||
                ((fmt_raw == FMT_R) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
    // An illegal word carries no format, so the immediate and the register-use
    // flags all fall out as zero.
    fmt_d = illegal_d ? FMT_NONE : fmt_raw;

    imm32 = '0;
    case (fmt_d)
      FMT_I:   imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:   imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U:   imm32 = {in_instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                        in_instr[20], in_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    // Extend from bit 31 so the same path serves XLEN=32 and XLEN=64.
    imm_d = XLEN'($signed(imm32));

    use_rs1_d = (fmt_d == FMT_R) || (fmt_d == FMT_I) || (fmt_d == FMT_S) || (fmt_d == FMT_B);
    use_rs2_d = (fmt_d == FMT_R) || (fmt_d == FMT_S) || (fmt_d == FMT_B);
    wr_rd_d   = ((fmt_d == FMT_R) || (fmt_d == FMT_I) || (fmt_d == FMT_U) || (fmt_d == FMT_J)) &&
                (in_instr[11:7] != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_opcode  <= '0;
      out_funct3  <= '0;
      out_funct7  <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_fmt     <= '0;
      out_imm     <= '0;
      out_use_rs1 <= 1'b0;
      out_use_rs2 <= 1'b0;
      out_wr_rd   <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_opcode  <= opc;
      out_funct3  <= in_instr[14:12];
      out_funct7  <= f7;
      out_rs1     <= in_instr[19:15];
      out_rs2     <= in_instr[24:20];
      out_rd      <= in_instr[11:7];
      out_fmt     <= fmt_d;
      out_imm     <= imm_d;
      out_use_rs1 <= use_rs1_d;
      out_use_rs2 <= use_rs2_d;
      out_wr_rd   <= wr_rd_d;
      out_illegal <= illegal_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DECODE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_decoded <= '0;
      stat_illegal <= '0;
    end else if (accept) begin
      if (stat_decoded != '1) stat_decoded <= stat_decoded + CNT_W'(1);
      if (illegal_d && (stat_illegal != '1)) stat_illegal <= stat_illegal + CNT_W'(1);
    end
  end
`endif

endmodule
